out_fold_sig: RTL and testbench
===============================

OUT_FOLD_SIG -- requirements
Module: out_fold_sig

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, meaning number of kernel output streams (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of each stream word; it is an integer multiple of OUT_W.
REQ-003 SHALL have parameter OUT_W, default 4, meaning width of the folded streaming output.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = stream fold only, 1 = stream fold plus run signature.
REQ-005 SHALL have ap_clk  input  1  the single clock, rising edge.
REQ-006 SHALL have ap_rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have ap_start  input  1  kernel start, level as driven to the kernel.
REQ-008 SHALL have ap_done  input  1  kernel done pulse.
REQ-009 SHALL have ch_din  input  NUM_CH*DATA_W  stream words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have ch_write  input  NUM_CH  per-channel write strobe.
REQ-011 SHALL have data_out  output  OUT_W  folded word.
REQ-012 SHALL have data_valid  output  1  data_out qualifier.
REQ-013 SHALL have sig_out  output  DATA_W  run signature.
REQ-014 SHALL have word_count  output  32  words absorbed in the current or last run.
REQ-015 SHALL have sig_valid  output  1  one-cycle pulse when sig_out and word_count are final.

Function
REQ-016 Fold of a word SHALL be the XOR of all DATA_W/OUT_W OUT_W-bit slices.
REQ-017 Stage 1 SHALL register, per channel, the fold of ch_din gated to zero when ch_write is low, plus v1 = OR of ch_write.
REQ-018 Stage 2 SHALL register data_valid <= v1, and data_out <= XOR of all stage-1 channel folds when v1 = 1, else 0.
REQ-019 Latency from ch_write to data_valid SHALL be exactly 2 cycles, with full throughput of one result per cycle and no backpressure.
REQ-020 Streaming fold SHALL operate in every FSM state and in both modes.
REQ-021 MODE=1 FSM states SHALL be IDLE, RUN, DRAIN, REPORT.
REQ-022 IDLE->RUN SHALL occur on a rising edge of ap_start, detected against the previous cycle's value, and SHALL clear sig_out to 0 and word_count to 0.
REQ-023 RUN->DRAIN SHALL occur on ap_done; ap_start edges during RUN, DRAIN and REPORT SHALL be ignored.
REQ-024 DRAIN SHALL last exactly 2 cycles and SHALL keep absorbing writes, covering writes coincident with ap_done.
REQ-025 DRAIN->REPORT SHALL occur after those 2 cycles; REPORT SHALL pulse sig_valid for 1 cycle and then return to IDLE.
REQ-026 In RUN or DRAIN, each cycle with any ch_write SHALL update sig_out <= rotl1(sig_out) XOR (XOR of the written channel words).
REQ-027 In RUN or DRAIN, each such cycle SHALL add popcount(ch_write) to word_count; word_count SHALL saturate at 0xFFFFFFFF.
REQ-028 Writes in IDLE or REPORT SHALL NOT affect sig_out or word_count.
REQ-029 sig_out and word_count SHALL hold their values after REPORT until the next run starts.
REQ-030 With MODE=0, the FSM and signature logic SHALL NOT be generated; sig_out, word_count and sig_valid SHALL be tied to 0.

Reset
REQ-031 While ap_rst is high, all registers SHALL clear asynchronously: data_out=0, data_valid=0, sig_out=0, word_count=0, sig_valid=0, FSM=IDLE, previous ap_start=0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no sig_valid pulse.
REQ-033 After reset, a run SHALL require a fresh ap_start rising edge.

Structure
REQ-034 Package out_fold_pkg SHALL hold the FSM state enum, the DRAIN_CYCLES=2 constant and the fold function width checks.
REQ-035 The per-channel fold SHALL be a sub-module fold_xor (DATA_W -> OUT_W, combinational), instantiated NUM_CH times.

Verification
REQ-036 NUM_CH=1, DATA_W=32, OUT_W=4; write 0x12345678 at cycle t -> data_valid=1 and data_out=0x8 at t+2, and 0 otherwise.
REQ-037 NUM_CH=2; ch0=0x12345678 and ch1=0x00000001 written in the same cycle -> data_out=0x9 and one data_valid pulse.
REQ-038 MODE=1; ap_start rises, then writes 0x00000001 then 0x00000002, then ap_done -> sig_valid pulses 3 cycles after ap_done, with sig_out=0x00000000 and word_count=2.
REQ-039 MODE=1; a write coincident with ap_done, plus a write during IDLE -> only the coincident write is counted in word_count.
REQ-040 MODE=1; ap_rst asserted during RUN -> all outputs read 0 immediately, no sig_valid, and the next run starts only on a new ap_start edge.
REQ-041 Back-to-back writes over 64 consecutive cycles -> 64 consecutive data_valid pulses with no gaps.

Source files
------------

// File: rtl/out_fold_pkg.sv
// Shared definitions for the output fold / run signature block: FSM state
// encoding, drain length and helpers that validate and size the word fold.
package out_fold_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } fsm_state_e;

    // Cycles spent absorbing late writes after ap_done before reporting.
    localparam int DRAIN_CYCLES = 2;

    // A word folds cleanly only when it splits into whole OUT_W slices.
    function automatic bit fold_width_ok(input int data_w, input int out_w);
        return (out_w > 0) && (data_w >= out_w) && ((data_w % out_w) == 0);
    endfunction

    // Number of slices XORed together; falls back to one slice on bad widths.
    function automatic int fold_slices(input int data_w, input int out_w);
        if (fold_width_ok(data_w, out_w)) begin
            return data_w / out_w;
        end else begin
            return 1;
        end
    endfunction

    // Population count of up to eight write strobes.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/out_fold_sig_fold_xor.sv
// Combinational fold of one stream word: XOR of all OUT_W-bit slices.
module fold_xor
    import out_fold_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 4
) (
    input  logic [DATA_W-1:0] din_i,
    output logic [OUT_W-1:0]  fold_o
);

    localparam int N_SLICES = fold_slices(DATA_W, OUT_W);

    // XOR every slice of the input word together.
    always_comb begin
        fold_o = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            fold_o = fold_o ^ din_i[s*OUT_W +: OUT_W];
        end
    end

endmodule

// File: rtl/out_fold_sig.sv
// Folds NUM_CH kernel output streams into one narrow OUT_W stream (two-stage
// pipeline, no backpressure) and, with MODE=1, accumulates a rotate-XOR
// signature and word count over each ap_start..ap_done run.
module out_fold_sig
    import out_fold_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 4,
    parameter int MODE   = 0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    input  logic                     ap_done,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    input  logic [NUM_CH-1:0]        ch_write,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_valid,
    output logic [DATA_W-1:0]        sig_out,
    output logic [31:0]              word_count,
    output logic                     sig_valid
);

    logic [NUM_CH-1:0][OUT_W-1:0] fold_s;
    logic [NUM_CH-1:0][OUT_W-1:0] fold1_d;
    logic [NUM_CH-1:0][OUT_W-1:0] fold1_q;
    logic                         v1_d;
    logic                         v1_q;
    logic [OUT_W-1:0]             fold_all_s;
    logic [OUT_W-1:0]             data_out_d;
    logic [OUT_W-1:0]             data_out_q;
    logic                         data_valid_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        fold_xor #(
            .DATA_W (DATA_W),
            .OUT_W  (OUT_W)
        ) u_fold (
            .din_i  (ch_din[k*DATA_W +: DATA_W]),
            .fold_o (fold_s[k])
        );
    end

    // Stage 1 next state: per-channel fold gated by its strobe, any-write flag.
    always_comb begin
        fold1_d = '0;
        v1_d    = |ch_write;
        for (int k = 0; k < NUM_CH; k++) begin
            fold1_d[k] = ch_write[k] ? fold_s[k] : {OUT_W{1'b0}};
        end
    end

    // Stage 1 registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            fold1_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            fold1_q <= fold1_d;
            v1_q    <= v1_d;
        end
    end

    // Stage 2 next state: combine channel folds, zero when nothing was written.
    always_comb begin
        fold_all_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fold_all_s = fold_all_s ^ fold1_q[k];
        end
        if (v1_q) begin
            data_out_d = fold_all_s;
        end else begin
            data_out_d = '0;
        end
    end

    // Stage 2 registers drive the streaming outputs directly.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= v1_q;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

    if (MODE == 1) begin : g_sig
        localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

        fsm_state_e        state_q;
        fsm_state_e        state_d;
        logic              start_prev_q;
        logic              start_rise_s;
        logic [1:0]        drain_cnt_q;
        logic [1:0]        drain_cnt_d;
        logic [DATA_W-1:0] sig_q;
        logic [DATA_W-1:0] sig_d;
        logic [DATA_W-1:0] wxor_s;
        logic [DATA_W-1:0] sig_next_s;
        logic [31:0]       cnt_q;
        logic [31:0]       cnt_d;
        logic [31:0]       cnt_next_s;
        logic [32:0]       cnt_sum_s;
        logic [7:0]        wr8_s;
        logic [3:0]        pop_s;
        logic              any_wr_s;
        logic              sig_valid_q;
        logic              sig_valid_d;

        assign start_rise_s = ap_start & ~start_prev_q;
        assign any_wr_s     = |ch_write;

        // Candidate signature and saturating count if this cycle is absorbed.
        always_comb begin
            wxor_s = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                wxor_s = wxor_s ^ (ch_write[k] ? ch_din[k*DATA_W +: DATA_W]
                                               : {DATA_W{1'b0}});
            end
            sig_next_s = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ wxor_s;
            wr8_s = 8'd0;
            wr8_s[NUM_CH-1:0] = ch_write;
            pop_s     = popcount8(wr8_s);
            cnt_sum_s = {1'b0, cnt_q} + {29'd0, pop_s};
            if (cnt_sum_s[32]) begin
                cnt_next_s = 32'hFFFF_FFFF;
            end else begin
                cnt_next_s = cnt_sum_s[31:0];
            end
        end

        // Run FSM: next state, signature/count update and report pulse.
        always_comb begin
            state_d     = state_q;
            drain_cnt_d = drain_cnt_q;
            sig_d       = sig_q;
            cnt_d       = cnt_q;
            sig_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_d = ST_RUN;
                        sig_d   = '0;
                        cnt_d   = 32'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (any_wr_s) begin
                        sig_d = sig_next_s;
                        cnt_d = cnt_next_s;
                    end else begin
                        sig_d = sig_q;
                    end
                    if (ap_done) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 2'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (any_wr_s) begin
                        sig_d = sig_next_s;
                        cnt_d = cnt_next_s;
                    end else begin
                        sig_d = sig_q;
                    end
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_REPORT;
                        drain_cnt_d = 2'd0;
                        sig_valid_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                    end
                end
                ST_REPORT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // FSM, signature, count and start-edge history registers.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state_q      <= ST_IDLE;
                start_prev_q <= 1'b0;
                drain_cnt_q  <= 2'd0;
                sig_q        <= '0;
                cnt_q        <= 32'd0;
                sig_valid_q  <= 1'b0;
            end else begin
                state_q      <= state_d;
                start_prev_q <= ap_start;
                drain_cnt_q  <= drain_cnt_d;
                sig_q        <= sig_d;
                cnt_q        <= cnt_d;
                sig_valid_q  <= sig_valid_d;
            end
        end

        assign sig_out    = sig_q;
        assign word_count = cnt_q;
        assign sig_valid  = sig_valid_q;
    end else begin : g_nosig
        logic unused_ctrl_s;
        assign unused_ctrl_s = ^{ap_start, ap_done};
        assign sig_out    = '0;
        assign word_count = 32'd0;
        assign sig_valid  = 1'b0;
    end

endmodule

// File: tb/tb_out_fold_sig.sv
// Directed bench: u1 is the single-channel stream-only build, u2 the
// two-channel build with the run signature enabled.
module tb_out_fold_sig;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [63:0] din2;
    logic [1:0]  wr2;

    logic [3:0]  do1, do2;
    logic        dv1, dv2;
    logic [31:0] sig1, sig2, cnt1, cnt2;
    logic        sv1, sv2;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;

    always #5 clk = ~clk;

    out_fold_sig #(.NUM_CH(1), .DATA_W(32), .OUT_W(4), .MODE(0)) u1 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done),
        .ch_din(din2[31:0]), .ch_write(wr2[0:0]),
        .data_out(do1), .data_valid(dv1), .sig_out(sig1),
        .word_count(cnt1), .sig_valid(sv1)
    );

    out_fold_sig #(.NUM_CH(2), .DATA_W(32), .OUT_W(4), .MODE(1)) u2 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done),
        .ch_din(din2), .ch_write(wr2),
        .data_out(do2), .data_valid(dv2), .sig_out(sig2),
        .word_count(cnt2), .sig_valid(sv2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; done = 1'b0; din2 = 64'd0; wr2 = 2'b00;
        tick(); tick();
        // reset state
        check("rst_do1", 64'(do1), 64'd0);
        check("rst_dv1", 64'(dv1), 64'd0);
        check("rst_sig1", 64'(sig1), 64'd0);
        check("rst_cnt1", 64'(cnt1), 64'd0);
        check("rst_sv1", 64'(sv1), 64'd0);
        check("rst_do2", 64'(do2), 64'd0);
        check("rst_dv2", 64'(dv2), 64'd0);
        check("rst_sig2", 64'(sig2), 64'd0);
        check("rst_cnt2", 64'(cnt2), 64'd0);
        check("rst_sv2", 64'(sv2), 64'd0);
        rst = 1'b0;
        tick();

        // single word fold, 2-cycle latency
        din2 = {32'h0, 32'h1234_5678}; wr2 = 2'b01;
        tick();
        check("lat1_dv1", 64'(dv1), 64'd0);
        wr2 = 2'b00;
        tick();
        check("lat2_dv1", 64'(dv1), 64'd1);
        check("lat2_do1", 64'(do1), 64'h8);
        check("lat2_do2", 64'(do2), 64'h8);
        tick();
        check("lat3_dv1", 64'(dv1), 64'd0);
        check("lat3_do1", 64'(do1), 64'd0);

        // two channels in one cycle
        din2 = {32'h0000_0001, 32'h1234_5678}; wr2 = 2'b11;
        tick();
        wr2 = 2'b00;
        tick();
        check("two_do2", 64'(do2), 64'h9);
        check("two_dv2", 64'(dv2), 64'd1);
        check("two_do1", 64'(do1), 64'h8);
        tick();
        check("two_dv2_end", 64'(dv2), 64'd0);

        // strobe gating: only channel 1 written
        din2 = {32'h0000_0001, 32'hFFFF_FFF0}; wr2 = 2'b10;
        tick();
        wr2 = 2'b00;
        tick();
        check("gate_do2", 64'(do2), 64'h1);
        check("gate_dv1", 64'(dv1), 64'd0);

        // basic run, with a start edge inside RUN that must be ignored
        start = 1'b1;
        tick();
        din2 = {32'h0, 32'h0000_0001}; wr2 = 2'b01; start = 1'b0;
        tick();
        din2 = {32'h0, 32'h0000_0002}; start = 1'b1;
        tick();
        wr2 = 2'b00; done = 1'b1;
        tick();
        check("run_sv_d0", 64'(sv2), 64'd0);
        done = 1'b0;
        tick();
        check("run_sv_d1", 64'(sv2), 64'd0);
        tick();
        check("run_sv", 64'(sv2), 64'd1);
        check("run_sig", 64'(sig2), 64'h0);
        check("run_cnt", 64'(cnt2), 64'd2);
        check("mode0_sv", 64'(sv1), 64'd0);
        check("mode0_cnt", 64'(cnt1), 64'd0);
        tick();
        check("run_sv_off", 64'(sv2), 64'd0);
        check("run_cnt_hold", 64'(cnt2), 64'd2);

        // IDLE write ignored, write coincident with ap_done and a DRAIN write absorbed
        start = 1'b0; din2 = {32'h0, 32'h0000_00A5}; wr2 = 2'b01;
        tick();
        wr2 = 2'b00; start = 1'b1;
        tick();
        check("clr_cnt", 64'(cnt2), 64'd0);
        check("clr_sig", 64'(sig2), 64'd0);
        din2 = {32'h8000_0000, 32'h0000_0003}; wr2 = 2'b11; done = 1'b1;
        tick();
        done = 1'b0; din2 = {32'h0, 32'h0000_0001}; wr2 = 2'b01;
        tick();
        wr2 = 2'b00;
        tick();
        check("co_sv", 64'(sv2), 64'd1);
        check("co_sig", 64'(sig2), 64'h6);
        check("co_cnt", 64'(cnt2), 64'd3);
        din2 = {32'h0, 32'h0000_00FF}; wr2 = 2'b01;
        tick();
        check("rep_sv_off", 64'(sv2), 64'd0);
        check("rep_sig", 64'(sig2), 64'h6);
        check("rep_cnt", 64'(cnt2), 64'd3);
        wr2 = 2'b00;
        tick();
        check("hold_sig", 64'(sig2), 64'h6);
        check("hold_cnt", 64'(cnt2), 64'd3);

        // reset in the middle of a run
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        din2 = {32'h0, 32'h0000_0005}; wr2 = 2'b01;
        tick();
        check("mid_cnt", 64'(cnt2), 64'd1);
        check("mid_sig", 64'(sig2), 64'h5);
        wr2 = 2'b00; rst = 1'b1; start = 1'b0;
        #1;
        check("arst_sig", 64'(sig2), 64'd0);
        check("arst_cnt", 64'(cnt2), 64'd0);
        check("arst_dv", 64'(dv2), 64'd0);
        check("arst_do", 64'(do2), 64'd0);
        check("arst_sv", 64'(sv2), 64'd0);
        tick(); tick();
        check("arst_sv_hold", 64'(sv2), 64'd0);
        rst = 1'b0;
        tick();
        din2 = {32'h0, 32'h0000_0007}; wr2 = 2'b01;
        tick();
        wr2 = 2'b00;
        tick(); tick(); tick();
        check("post_rst_cnt", 64'(cnt2), 64'd0);
        check("post_rst_sv", 64'(sv2), 64'd0);
        start = 1'b1;
        tick();
        din2 = {32'h0, 32'h0000_0003}; wr2 = 2'b01; done = 1'b1;
        tick();
        wr2 = 2'b00; done = 1'b0;
        tick(); tick();
        check("new_sv", 64'(sv2), 64'd1);
        check("new_cnt", 64'(cnt2), 64'd1);
        check("new_sig", 64'(sig2), 64'h3);
        start = 1'b0;
        tick();

        // 64 back-to-back writes
        for (int i = 0; i < 66; i++) begin
            logic [7:0] pv;
            logic [3:0] exp_do;
            logic       exp_dv;
            if (i < 64) begin
                din2 = {32'h0, 24'h0, 8'(i * 3)};
                wr2  = 2'b01;
            end else begin
                wr2 = 2'b00;
            end
            tick();
            pv     = 8'((i - 1) * 3);
            exp_dv = (i >= 1) && (i <= 64);
            exp_do = exp_dv ? (pv[3:0] ^ pv[7:4]) : 4'h0;
            if (dv1) begin
                run_len++;
            end else begin
                run_len = run_len;
            end
            check("burst_dv", 64'(dv1), 64'(exp_dv));
            check("burst_do", 64'(do1), 64'(exp_do));
        end
        check("burst_len", 64'(run_len), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
